// File: rtl/ttt_processor_bank.sv
// Per-processor saturating good/bad token counters with a fire-event FIFO of processor ids.
// Define TTT_PROC_BANK_STATUS_EN to add combinational counter read-back ports.
module ttt_processor_bank #(
   parameter int NUM_PROCESSORS = 10,
   parameter int NEW_TOKEN_BITS = 4,
   parameter int TOKEN_BITS     = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              token_valid,
   input  logic [$clog2(NUM_PROCESSORS)-1:0] target_id,
   input  logic [NEW_TOKEN_BITS-1:0]         new_good_tokens,
   input  logic [NEW_TOKEN_BITS-1:0]         new_bad_tokens,
   input  logic                              prog_write,
   input  logic [$clog2(NUM_PROCESSORS)-1:0] prog_id,
   input  logic                              prog_sel,
   input  logic [TOKEN_BITS-1:0]             prog_value,
   output logic                              out_valid,
   output logic [$clog2(NUM_PROCESSORS)-1:0] out_processor_id,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              overflow
`ifdef TTT_PROC_BANK_STATUS_EN
   ,
   input  logic [$clog2(NUM_PROCESSORS)-1:0] status_id,
   output logic [TOKEN_BITS-1:0]             status_good,
   output logic [TOKEN_BITS-1:0]             status_bad
`endif
);

   localparam int ID_W  = $clog2(NUM_PROCESSORS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SW    = TOKEN_BITS + 2;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCESSORS - 1);

   logic [TOKEN_BITS-1:0] good_cnt [NUM_PROCESSORS];
   logic [TOKEN_BITS-1:0] bad_cnt  [NUM_PROCESSORS];
   logic [TOKEN_BITS-1:0] good_thr [NUM_PROCESSORS];
   logic [TOKEN_BITS-1:0] bad_thr  [NUM_PROCESSORS];

   logic [ID_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic [ID_W-1:0]  head;

   logic prog_en, upd_en, fire, pop, full, push, drop;
   logic [TOKEN_BITS-1:0] good_next, bad_next;

   // Add a signed increment in a two-bit-wider signed domain, then clamp to [0, max].
   function automatic logic [TOKEN_BITS-1:0] sat_add(input logic [TOKEN_BITS-1:0] cur,
                                                     input logic [NEW_TOKEN_BITS-1:0] inc);
      logic signed [SW-1:0] sum;
      sum = $signed({2'b00, cur}) + SW'($signed(inc));
      if (sum[SW-1])      return '0;
      else if (sum[SW-2]) return '1;
      else                return sum[TOKEN_BITS-1:0];
   endfunction

   always_comb begin
      prog_en   = prog_write && (prog_id <= LAST_ID);
      upd_en    = token_valid && (target_id <= LAST_ID) && !(prog_en && (prog_id == target_id));
      good_next = sat_add(good_cnt[target_id], new_good_tokens);
      bad_next  = sat_add(bad_cnt[target_id], new_bad_tokens);
      fire      = upd_en && (good_next >= good_thr[target_id]) && (bad_next < bad_thr[target_id]);
      pop       = (count != '0) && out_ready;
      full      = (count == CNT_W'(FIFO_DEPTH));
      push      = fire && (!full || pop);
      drop      = fire && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PROCESSORS; i++) begin
            good_cnt[i] <= '0;
            bad_cnt[i]  <= '0;
            good_thr[i] <= TOKEN_BITS'(1);
            bad_thr[i]  <= '1;
         end
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head     <= '0;
         overflow <= 1'b0;
      end else begin
         if (upd_en) begin
            good_cnt[target_id] <= fire ? '0 : good_next;
            bad_cnt[target_id]  <= fire ? '0 : bad_next;
         end
         if (prog_en) begin
            if (prog_sel) bad_thr[prog_id]  <= prog_value;
            else          good_thr[prog_id] <= prog_value;
            good_cnt[prog_id] <= '0;
            bad_cnt[prog_id]  <= '0;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         // Registered head: load the pushed id when it lands in an emptied FIFO,
         // advance on pop while entries remain, otherwise hold the last value.
         if (push && (count == CNT_W'(pop)))
            head <= target_id;
         else if (pop && (count > CNT_W'(1)))
            head <= mem[PTR_W'(rd_ptr + 1'b1)];
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= target_id;
   end

   assign out_valid        = (count != '0);
   assign out_processor_id = head;
   assign fifo_count       = count;

`ifdef TTT_PROC_BANK_STATUS_EN
   assign status_good = (status_id <= LAST_ID) ? good_cnt[status_id] : '0;
   assign status_bad  = (status_id <= LAST_ID) ? bad_cnt[status_id]  : '0;
`endif

endmodule
